// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter's tx_data/tx_start strobe.
// Dispatches the next byte as soon as the transmitter drops tx_busy.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          overflow
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wp;
    logic [AW:0] rp;
    logic        push;
    logic        pop;

    assign level    = wp - rp;
    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(DEPTH));
    assign in_ready = ~full;

    // A push coinciding with flush is discarded so the FIFO ends empty.
    assign push = in_valid & in_ready & ~flush;

    // tx_start gates a second strobe until the transmitter raises tx_busy.
    assign pop = ~empty & ~tx_busy & ~tx_start & ~flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + (AW+1)'(1);
            end
            if (flush) begin
                rp <= wp;
            end else if (pop) begin
                rp <= rp + (AW+1)'(1);
            end
            tx_start <= pop;
            if (pop) begin
                tx_data <= mem[rp[AW-1:0]];
            end
            if (flush) begin
                overflow <= 1'b0;
            end else if (in_valid & full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
